// File: rtl/input_event_ctrl.sv
// Input-event controller: synchronizes and debounces buttons/switches, latches press and
// switch-change events as sticky pending flags until acknowledged, and raises a level irq.
//
// Button debounce states:
//   state | meaning
//   REL   | released, btn_db=0
//   PWAIT | candidate press, counting stable high samples
//   PRS   | pressed, btn_db=1
//   RWAIT | candidate release, counting stable low samples
module input_event_ctrl #(
  parameter int N_BTN           = 3,
  parameter int N_SW            = 16,
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_BTN-1:0] btn_raw,
  input  logic [N_SW-1:0]  sw_raw,
  input  logic [N_BTN:0]   ack,
  output logic [N_BTN-1:0] btn_db,
  output logic [N_SW-1:0]  sw_db,
  output logic [N_BTN:0]   evt,
  output logic [N_BTN:0]   ovr,
  output logic             irq
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  // Timers count down; loading DEBOUNCE_CYCLES-2 on the first stable sample means the
  // commit lands on the DEBOUNCE_CYCLES-th consecutive stable sample.
  localparam logic [CW-1:0] CNT_LOAD = CW'(DEBOUNCE_CYCLES - 2);

  typedef enum logic [1:0] {REL, PWAIT, PRS, RWAIT} btn_state_e;

  logic [N_BTN-1:0] btn_s1, btn_s2;
  logic [N_SW-1:0]  sw_s1, sw_s2;

  btn_state_e       state_q [N_BTN];
  btn_state_e       state_d [N_BTN];
  logic [CW-1:0]    cnt_q   [N_BTN];
  logic [CW-1:0]    cnt_d   [N_BTN];
  logic [N_BTN-1:0] press_fire;

  logic [N_SW-1:0]  sw_cand_q, sw_cand_d, sw_db_d;
  logic [CW-1:0]    sw_cnt_q, sw_cnt_d;
  logic             sw_fire;

  logic [N_BTN:0]   fire, evt_d, ovr_d;

  always_comb begin
    press_fire = '0;
    for (int i = 0; i < N_BTN; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      case (state_q[i])
        REL: begin
          if (btn_s2[i]) begin
            state_d[i] = PWAIT;
            cnt_d[i]   = CNT_LOAD;
          end
        end
        PWAIT: begin
          if (!btn_s2[i]) begin
            state_d[i] = REL;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] == '0) begin
            state_d[i]    = PRS;
            press_fire[i] = 1'b1;
          end else begin
            cnt_d[i] = cnt_q[i] - 1'b1;
          end
        end
        PRS: begin
          if (!btn_s2[i]) begin
            state_d[i] = RWAIT;
            cnt_d[i]   = CNT_LOAD;
          end
        end
        RWAIT: begin
          if (btn_s2[i]) begin
            state_d[i] = PRS;
          end else if (cnt_q[i] == '0) begin
            state_d[i] = REL;
          end else begin
            cnt_d[i] = cnt_q[i] - 1'b1;
          end
        end
        default: begin
          state_d[i] = REL;
          cnt_d[i]   = '0;
        end
      endcase
    end
  end

  always_comb begin
    btn_db = '0;
    for (int i = 0; i < N_BTN; i++) begin
      btn_db[i] = (state_q[i] == PRS) || (state_q[i] == RWAIT);
    end
  end

  // One counter serves the whole switch vector; any change to the candidate restarts it.
  always_comb begin
    sw_cand_d = sw_cand_q;
    sw_db_d   = sw_db;
    sw_cnt_d  = sw_cnt_q;
    sw_fire   = 1'b0;
    if (sw_s2 != sw_cand_q) begin
      sw_cand_d = sw_s2;
      sw_cnt_d  = CNT_LOAD;
    end else if (sw_cand_q != sw_db) begin
      if (sw_cnt_q == '0) begin
        sw_db_d = sw_cand_q;
        sw_fire = 1'b1;
      end else begin
        sw_cnt_d = sw_cnt_q - 1'b1;
      end
    end
  end

  // A fire coinciding with ack wins and counts as a fresh event, not an overrun.
  always_comb begin
    fire  = {sw_fire, press_fire};
    evt_d = fire | (evt & ~ack);
    ovr_d = (ovr | (fire & evt)) & ~ack;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      btn_s1    <= '0;
      btn_s2    <= '0;
      sw_s1     <= '0;
      sw_s2     <= '0;
      sw_cand_q <= '0;
      sw_db     <= '0;
      sw_cnt_q  <= '0;
      evt       <= '0;
      ovr       <= '0;
      irq       <= 1'b0;
      for (int i = 0; i < N_BTN; i++) begin
        state_q[i] <= REL;
        cnt_q[i]   <= '0;
      end
    end else begin
      btn_s1    <= btn_raw;
      btn_s2    <= btn_s1;
      sw_s1     <= sw_raw;
      sw_s2     <= sw_s1;
      sw_cand_q <= sw_cand_d;
      sw_db     <= sw_db_d;
      sw_cnt_q  <= sw_cnt_d;
      evt       <= evt_d;
      ovr       <= ovr_d;
      irq       <= |evt_d;
      for (int i = 0; i < N_BTN; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
    end
  end

endmodule

// File: tb/tb_input_event_ctrl.sv
// Scoreboard bench for input_event_ctrl: a run-length reference model predicts all outputs
// for every clock edge; a monitor compares them against the DUT after each edge.
module tb_input_event_ctrl;

  localparam int N_BTN = 3;
  localparam int N_SW  = 16;
  localparam int D     = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [N_BTN-1:0] btn_raw;
  logic [N_SW-1:0]  sw_raw;
  logic [N_BTN:0]   ack;
  logic [N_BTN-1:0] btn_db;
  logic [N_SW-1:0]  sw_db;
  logic [N_BTN:0]   evt;
  logic [N_BTN:0]   ovr;
  logic             irq;

  input_event_ctrl #(.N_BTN(N_BTN), .N_SW(N_SW), .DEBOUNCE_CYCLES(D)) dut (
    .clk(clk), .rst_n(rst_n), .btn_raw(btn_raw), .sw_raw(sw_raw), .ack(ack),
    .btn_db(btn_db), .sw_db(sw_db), .evt(evt), .ovr(ovr), .irq(irq)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [N_BTN-1:0] btn_db;
    logic [N_SW-1:0]  sw_db;
    logic [N_BTN:0]   evt;
    logic [N_BTN:0]   ovr;
    logic             irq;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Reference model: raw inputs reach the debouncers two edges late; a level commits once
  // it has been seen unchanged (and different from the debounced value) for D edges.
  logic [N_BTN-1:0] m_b1, m_b2, m_db;
  logic [N_SW-1:0]  m_s1, m_s2, m_sw_db, m_sw_last;
  int               m_run [N_BTN];
  int               m_sw_run;
  logic [N_BTN:0]   m_evt, m_ovr;

  function automatic void model_edge();
    logic [N_BTN:0]   fire;
    logic [N_BTN-1:0] sb;
    logic [N_SW-1:0]  ss;
    exp_t             e;
    fire = '0;
    if (!rst_n) begin
      m_b1 = '0; m_b2 = '0; m_db = '0;
      m_s1 = '0; m_s2 = '0; m_sw_db = '0; m_sw_last = '0; m_sw_run = 0;
      for (int i = 0; i < N_BTN; i++) m_run[i] = 0;
      m_evt = '0; m_ovr = '0;
    end else begin
      sb = m_b2; ss = m_s2;
      m_b2 = m_b1; m_b1 = btn_raw;
      m_s2 = m_s1; m_s1 = sw_raw;
      for (int i = 0; i < N_BTN; i++) begin
        if (sb[i] != m_db[i]) begin
          m_run[i] = m_run[i] + 1;
          if (m_run[i] == D) begin
            m_db[i]  = sb[i];
            m_run[i] = 0;
            if (sb[i]) fire[i] = 1'b1;
          end
        end else begin
          m_run[i] = 0;
        end
      end
      if (ss != m_sw_db) begin
        m_sw_run = (ss == m_sw_last) ? m_sw_run + 1 : 1;
        if (m_sw_run == D) begin
          m_sw_db     = ss;
          m_sw_run    = 0;
          fire[N_BTN] = 1'b1;
        end
      end else begin
        m_sw_run = 0;
      end
      m_sw_last = ss;
      m_ovr = (m_ovr | (fire & m_evt)) & ~ack;
      m_evt = fire | (m_evt & ~ack);
    end
    e.btn_db = m_db;
    e.sw_db  = m_sw_db;
    e.evt    = m_evt;
    e.ovr    = m_ovr;
    e.irq    = |m_evt;
    exp_q.push_back(e);
  endfunction

  // Inputs are already set; predict the next edge, then move to the following negedge.
  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      model_edge();
      @(negedge clk);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        vectors++;
        if ({btn_db, sw_db, evt, ovr, irq} !== e) begin
          miscompares++;
          $display("FAIL outputs t=%0t actual btn_db=%h sw_db=%h evt=%h ovr=%h irq=%b expected btn_db=%h sw_db=%h evt=%h ovr=%h irq=%b",
                   $time, btn_db, sw_db, evt, ovr, irq, e.btn_db, e.sw_db, e.evt, e.ovr, e.irq);
        end
      end
    end
  end

  initial begin : driver
    int idx;
    rst_n = 1'b0; btn_raw = '0; sw_raw = '0; ack = '0;
    step(3);
    rst_n = 1'b1;
    step(2);

    // clean press and release of button 0
    btn_raw[0] = 1'b1; step(20);
    btn_raw[0] = 1'b0; step(20);

    // bouncing button 1, then a steady press
    for (int k = 0; k < 10; k++) begin
      btn_raw[1] = ~btn_raw[1];
      step(3);
    end
    btn_raw[1] = 1'b1; step(20);
    btn_raw[1] = 1'b0; step(15);

    // overrun on button 2, then a one-cycle ack
    btn_raw[2] = 1'b1; step(15);
    btn_raw[2] = 1'b0; step(15);
    btn_raw[2] = 1'b1; step(15);
    ack[2] = 1'b1; step(1);
    ack = '0; btn_raw[2] = 1'b0; step(15);
    ack = '1; step(1);
    ack = '0;

    // ack held across a commit
    btn_raw[0] = 1'b1; step(15);
    btn_raw[0] = 1'b0; step(15);
    ack[0] = 1'b1; btn_raw[0] = 1'b1; step(11);
    ack = '0; step(5);
    btn_raw[0] = 1'b0; step(15);

    // ack only on the commit edge while the previous event is still pending
    btn_raw[0] = 1'b1; step(15);
    btn_raw[0] = 1'b0; step(15);
    btn_raw[0] = 1'b1; step(9);
    ack[0] = 1'b1; step(1);
    ack = '0; step(5);
    btn_raw[0] = 1'b0; step(15);

    // switch vector change with one bit bouncing, then a short pulse
    sw_raw = 16'h00A5;
    for (int k = 0; k < 5; k++) begin
      sw_raw[0] = ~sw_raw[0];
      step(1);
    end
    sw_raw = 16'h00A5; step(20);
    sw_raw[15] = 1'b1; step(4);
    sw_raw[15] = 1'b0; step(20);

    // all sources pending, then reset in the middle of a press
    btn_raw = '1; step(15);
    sw_raw = 16'h5A00; step(15);
    btn_raw = '0; step(15);
    btn_raw[0] = 1'b1; step(7);
    rst_n = 1'b0; step(1);
    rst_n = 1'b1; step(20);
    btn_raw = '0; step(15);

    // randomized traffic
    for (int c = 0; c < 2000; c++) begin
      if ($urandom_range(5) == 0) begin
        idx = int'($urandom_range(N_BTN - 1));
        btn_raw[idx] = ~btn_raw[idx];
      end
      if ($urandom_range(9) == 0) begin
        idx = int'($urandom_range(N_SW - 1));
        sw_raw[idx] = ~sw_raw[idx];
      end
      ack   = ($urandom_range(7) == 0) ? (N_BTN+1)'($urandom) : '0;
      rst_n = ($urandom_range(599) != 0);
      step(1);
    end
    rst_n = 1'b1; ack = '0;
    step(2);

    @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain actual %0d left, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
